// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU / SPI-slave / RAM environment and mem_arbiter.
//   cpu_*  : 68k-style asynchronous bus (strobes active low, rw=1 read)
//   spi_*  : single-cycle byte request pulses from the SPI slave
//   mem_*  : single-port RAM, 1-cycle registered read
// modport master : environment side (drives requests and RAM read data)
// modport slave  : arbiter side
interface mem_arbiter_if #(
    parameter int AW = 15
);
    logic          cpu_as_n;
    logic          cpu_uds_n;
    logic          cpu_lds_n;
    logic          cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_dout;
    logic [15:0]   cpu_din;
    logic          cpu_dtack_n;

    logic          spi_wr;
    logic          spi_rd;
    logic [AW:0]   spi_addr;
    logic [7:0]    spi_di;
    logic [7:0]    spi_do;
    logic          spi_ack;
    logic          spi_busy;
    logic          spi_ovr;

    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic          mem_we;
    logic          mem_ub;
    logic          mem_lb;
    logic [15:0]   mem_dout;

    modport master (
        output cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_addr, cpu_dout,
        input  cpu_din, cpu_dtack_n,
        output spi_wr, spi_rd, spi_addr, spi_di,
        input  spi_do, spi_ack, spi_busy, spi_ovr,
        input  mem_addr, mem_din, mem_we, mem_ub, mem_lb,
        output mem_dout
    );

    modport slave (
        input  cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_addr, cpu_dout,
        output cpu_din, cpu_dtack_n,
        input  spi_wr, spi_rd, spi_addr, spi_di,
        output spi_do, spi_ack, spi_busy, spi_ovr,
        output mem_addr, mem_din, mem_we, mem_ub, mem_lb,
        input  mem_dout
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 16-bit RAM between a 68k CPU bus and
// an SPI slave issuing byte requests.
//   clk     : CPU clock
//   reset_n : asynchronous active-low reset
//   bus     : mem_arbiter_if.slave (CPU bus, SPI request/response, RAM port)
// Parameters: AW word-address width, WAIT read wait cycles (1..7).
// All outputs are registered; RAM controls are set on the edge entering an
// access state so they are stable for the whole access cycle.
module mem_arbiter #(
    parameter int AW   = 15,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, CPU_ACC, CPU_WAIT, CPU_DONE, SPI_ACC, SPI_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic          served_q, served_d;
    logic          last_spi_q, last_spi_d;   // 1: SPI was granted last
    logic [2:0]    wcnt_q, wcnt_d;
    logic          buf_vld_q, buf_vld_d;
    logic          buf_wr_q, buf_wr_d;
    logic [AW:0]   buf_addr_q, buf_addr_d;
    logic [7:0]    buf_di_q, buf_di_d;
    logic          spi_ovr_q, spi_ovr_d;
    logic          spi_ack_q, spi_ack_d;
    logic [7:0]    spi_do_q, spi_do_d;
    logic [15:0]   cpu_din_q, cpu_din_d;
    logic          dtack_n_q, dtack_n_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]   mem_din_q, mem_din_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_ub_q, mem_ub_d;
    logic          mem_lb_q, mem_lb_d;

    logic cpu_req, spi_pulse;

    always_comb begin
        state_d    = state_q;
        served_d   = served_q;
        last_spi_d = last_spi_q;
        wcnt_d     = wcnt_q;
        buf_vld_d  = buf_vld_q;
        buf_wr_d   = buf_wr_q;
        buf_addr_d = buf_addr_q;
        buf_di_d   = buf_di_q;
        spi_ovr_d  = spi_ovr_q;
        spi_ack_d  = 1'b0;
        spi_do_d   = spi_do_q;
        cpu_din_d  = cpu_din_q;
        dtack_n_d  = dtack_n_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_d   = 1'b0;
        mem_ub_d   = mem_ub_q;
        mem_lb_d   = mem_lb_q;

        cpu_req   = !bus.cpu_as_n && (!bus.cpu_uds_n || !bus.cpu_lds_n) && !served_q;
        spi_pulse = bus.spi_wr || bus.spi_rd;

        if (bus.cpu_as_n)
            served_d = 1'b0;

        // The buffer frees on the SPI_WAIT edge, so a pulse landing in that
        // same cycle takes the slot instead of counting as an overrun.
        if (state_q == SPI_WAIT)
            buf_vld_d = 1'b0;
        if (spi_pulse) begin
            if (!buf_vld_q || state_q == SPI_WAIT) begin
                buf_vld_d  = 1'b1;
                buf_wr_d   = bus.spi_wr;
                buf_addr_d = bus.spi_addr;
                buf_di_d   = bus.spi_di;
            end else begin
                spi_ovr_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                // CPU wins unless SPI is also pending and CPU went last.
                if (cpu_req && (!buf_vld_q || last_spi_q)) begin
                    state_d    = CPU_ACC;
                    last_spi_d = 1'b0;
                    mem_addr_d = bus.cpu_addr;
                    mem_din_d  = bus.cpu_dout;
                    mem_ub_d   = !bus.cpu_uds_n;
                    mem_lb_d   = !bus.cpu_lds_n;
                    mem_we_d   = !bus.cpu_rw;
                end else if (buf_vld_q) begin
                    state_d    = SPI_ACC;
                    last_spi_d = 1'b1;
                    mem_addr_d = buf_addr_q[AW:1];
                    mem_din_d  = {buf_di_q, buf_di_q};
                    mem_ub_d   = !buf_addr_q[0];
                    mem_lb_d   = buf_addr_q[0];
                    mem_we_d   = buf_wr_q;
                end
            end
            CPU_ACC: begin
                if (bus.cpu_as_n) begin
                    state_d = IDLE;
                end else if (!bus.cpu_rw) begin
                    state_d   = CPU_DONE;
                    dtack_n_d = 1'b0;
                    served_d  = 1'b1;
                end else begin
                    state_d = CPU_WAIT;
                    wcnt_d  = 3'(WAIT - 1);
                end
            end
            CPU_WAIT: begin
                if (bus.cpu_as_n) begin
                    state_d = IDLE;
                end else if (wcnt_q == 3'd0) begin
                    state_d   = CPU_DONE;
                    cpu_din_d = bus.mem_dout;
                    dtack_n_d = 1'b0;
                    served_d  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            CPU_DONE: begin
                if (bus.cpu_as_n) begin
                    state_d   = IDLE;
                    dtack_n_d = 1'b1;
                end
            end
            SPI_ACC: state_d = SPI_WAIT;
            SPI_WAIT: begin
                if (!buf_wr_q)
                    spi_do_d = buf_addr_q[0] ? bus.mem_dout[7:0] : bus.mem_dout[15:8];
                spi_ack_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            served_q   <= 1'b0;
            last_spi_q <= 1'b1;
            wcnt_q     <= 3'd0;
            buf_vld_q  <= 1'b0;
            buf_wr_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_di_q   <= 8'd0;
            spi_ovr_q  <= 1'b0;
            spi_ack_q  <= 1'b0;
            spi_do_q   <= 8'd0;
            cpu_din_q  <= 16'd0;
            dtack_n_q  <= 1'b1;
            mem_addr_q <= '0;
            mem_din_q  <= 16'd0;
            mem_we_q   <= 1'b0;
            mem_ub_q   <= 1'b0;
            mem_lb_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            served_q   <= served_d;
            last_spi_q <= last_spi_d;
            wcnt_q     <= wcnt_d;
            buf_vld_q  <= buf_vld_d;
            buf_wr_q   <= buf_wr_d;
            buf_addr_q <= buf_addr_d;
            buf_di_q   <= buf_di_d;
            spi_ovr_q  <= spi_ovr_d;
            spi_ack_q  <= spi_ack_d;
            spi_do_q   <= spi_do_d;
            cpu_din_q  <= cpu_din_d;
            dtack_n_q  <= dtack_n_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_we_q   <= mem_we_d;
            mem_ub_q   <= mem_ub_d;
            mem_lb_q   <= mem_lb_d;
        end
    end

    assign bus.cpu_din     = cpu_din_q;
    assign bus.cpu_dtack_n = dtack_n_q;
    assign bus.spi_do      = spi_do_q;
    assign bus.spi_ack     = spi_ack_q;
    assign bus.spi_busy    = buf_vld_q;
    assign bus.spi_ovr     = spi_ovr_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_din     = mem_din_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_ub      = mem_ub_q;
    assign bus.mem_lb      = mem_lb_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed timing scenarios plus random
// CPU/SPI traffic checked against a word-array shadow of RAM contents.
module tb_mem_arbiter;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #20 clk = ~clk;

    mem_arbiter_if #(.AW(AW)) bus ();

    mem_arbiter #(.AW(AW), .WAIT(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // RAM model: 256 words, byte-enabled write, registered read.
    logic [15:0] ram [256];
    logic        ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= (i == 16) ? 16'hBEEF : 16'h0000;
            ram_init <= 1'b1;
        end else if (bus.mem_we) begin
            if (bus.mem_ub) ram[bus.mem_addr[7:0]][15:8] <= bus.mem_din[15:8];
            if (bus.mem_lb) ram[bus.mem_addr[7:0]][7:0]  <= bus.mem_din[7:0];
        end
        bus.mem_dout <= ram[bus.mem_addr[7:0]];
    end

    // Write-strobe monitor, sampled mid-cycle.
    int            we_cnt = 0, we_viol = 0;
    logic          prev_we = 1'b0;
    logic [AW-1:0] we_addr = '0;
    logic          we_ub = 1'b0, we_lb = 1'b0;
    always begin
        @(posedge clk);
        #5;
        if (bus.mem_we) begin
            we_cnt++;
            we_addr = bus.mem_addr;
            we_ub   = bus.mem_ub;
            we_lb   = bus.mem_lb;
            if (prev_we) we_viol++;
        end
        prev_we = bus.mem_we;
    end

    logic [15:0] shadow [256];
    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_dtack", bus.cpu_dtack_n, 1);
        chk("rst_din",   bus.cpu_din, 0);
        chk("rst_spido", bus.spi_do, 0);
        chk("rst_ack",   bus.spi_ack, 0);
        chk("rst_busy",  bus.spi_busy, 0);
        chk("rst_ovr",   bus.spi_ovr, 0);
        chk("rst_memctl", {bus.mem_we, bus.mem_ub, bus.mem_lb}, 0);
        chk("rst_maddr", bus.mem_addr, 0);
        chk("rst_mdin",  bus.mem_din, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic cpu_op(input logic rw, input logic [AW-1:0] a, input logic [1:0] be,
                          input logic [15:0] wd, output logic [15:0] rd, output int lat);
        @(negedge clk);
        bus.cpu_as_n = 1'b0; bus.cpu_rw = rw; bus.cpu_addr = a;
        bus.cpu_uds_n = !be[1]; bus.cpu_lds_n = !be[0]; bus.cpu_dout = wd;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!bus.cpu_dtack_n) begin lat = c; break; end
        end
        rd = bus.cpu_din;
        bus.cpu_as_n = 1'b1; bus.cpu_uds_n = 1'b1; bus.cpu_lds_n = 1'b1; bus.cpu_rw = 1'b1;
        if (lat > 0) begin
            @(negedge clk);
            chk("dtack_release", bus.cpu_dtack_n, 1);
        end
    endtask

    task automatic spi_op(input logic wr, input logic [AW:0] ba, input logic [7:0] di,
                          output logic [7:0] d, output int lat);
        @(negedge clk);
        bus.spi_wr = wr; bus.spi_rd = !wr; bus.spi_addr = ba; bus.spi_di = di;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin bus.spi_wr = 1'b0; bus.spi_rd = 1'b0; end
            if (bus.spi_ack) begin lat = c; break; end
        end
        d = bus.spi_do;
    endtask

    // Shadow helpers: byte-lane semantics of the RAM as seen by each requester.
    task automatic sh_cpu_wr(input logic [AW-1:0] a, input logic [1:0] be, input logic [15:0] wd);
        if (be[1]) shadow[a[7:0]][15:8] = wd[15:8];
        if (be[0]) shadow[a[7:0]][7:0]  = wd[7:0];
    endtask

    function automatic logic [7:0] sh_byte(input logic [AW:0] ba);
        logic [15:0] w;
        w = shadow[ba[8:1]];
        return ba[0] ? w[7:0] : w[15:8];
    endfunction

    task automatic sh_spi_wr(input logic [AW:0] ba, input logic [7:0] di);
        if (ba[0]) shadow[ba[8:1]][7:0] = di;
        else       shadow[ba[8:1]][15:8] = di;
    endtask

    initial begin
        logic [15:0] rd, rdv;
        logic [7:0]  sd;
        int lat, w0, t_dt, t_ack, t_a1, t_a2, seen;

        for (int i = 0; i < 256; i++) shadow[i] = 16'h0000;
        shadow[16] = 16'hBEEF;
        bus.cpu_as_n = 1'b1; bus.cpu_uds_n = 1'b1; bus.cpu_lds_n = 1'b1; bus.cpu_rw = 1'b1;
        bus.cpu_addr = '0; bus.cpu_dout = '0;
        bus.spi_wr = 1'b0; bus.spi_rd = 1'b0; bus.spi_addr = '0; bus.spi_di = '0;

        do_reset();

        // CPU word read with dtack timing.
        cpu_op(1'b1, 15'h0010, 2'b11, 16'h0, rd, lat);
        chk("rd_lat", lat, 3);
        chk("rd_data", rd, shadow[16]);

        // CPU low-byte write.
        w0 = we_cnt;
        cpu_op(1'b0, 15'h0020, 2'b01, 16'h12AB, rd, lat);
        sh_cpu_wr(15'h0020, 2'b01, 16'h12AB);
        chk("wr_lat", lat, 2);
        chk("wr_pulses", we_cnt - w0, 1);
        chk("wr_lanes", {we_ub, we_lb}, 2'b01);
        chk("wr_addr", we_addr, 15'h0020);
        cpu_op(1'b1, 15'h0020, 2'b11, 16'h0, rd, lat);
        chk("wr_readback", rd, shadow[32]);

        // SPI byte write then read-back.
        w0 = we_cnt;
        spi_op(1'b1, 16'h0041, 8'h5A, sd, lat);
        sh_spi_wr(16'h0041, 8'h5A);
        chk("spi_wr_lat", lat, 4);
        chk("spi_wr_pulses", we_cnt - w0, 1);
        chk("spi_wr_addr", we_addr, 15'h0020);
        chk("spi_wr_lanes", {we_ub, we_lb}, 2'b01);
        spi_op(1'b0, 16'h0041, 8'h00, sd, lat);
        chk("spi_rd_lat", lat, 4);
        chk("spi_rd_data", sd, sh_byte(16'h0041));

        // Second pulse in the cycle the buffer frees is accepted.
        @(negedge clk);
        bus.spi_wr = 1'b1; bus.spi_addr = 16'h0090; bus.spi_di = 8'h11;
        t_a1 = -1; t_a2 = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) bus.spi_wr = 1'b0;
            if (c == 3) begin bus.spi_wr = 1'b1; bus.spi_addr = 16'h0091; bus.spi_di = 8'h22; end
            if (c == 4) bus.spi_wr = 1'b0;
            if (bus.spi_ack && t_a1 < 0) t_a1 = c;
            else if (bus.spi_ack && t_a2 < 0) t_a2 = c;
        end
        sh_spi_wr(16'h0090, 8'h11);
        sh_spi_wr(16'h0091, 8'h22);
        chk("b2b_ack1", t_a1, 4);
        chk("b2b_ack2", t_a2, 7);
        chk("b2b_no_ovr", bus.spi_ovr, 0);
        spi_op(1'b0, 16'h0091, 8'h00, sd, lat);
        chk("b2b_rd1", sd, sh_byte(16'h0091));
        spi_op(1'b0, 16'h0090, 8'h00, sd, lat);
        chk("b2b_rd0", sd, sh_byte(16'h0090));

        // Random sequential traffic.
        for (int n = 0; n < 80; n++) begin
            int k;
            logic [AW-1:0] a;
            logic [AW:0]   ba;
            logic [1:0]    be;
            logic [15:0]   wd;
            k  = $urandom_range(0, 3);
            a  = 15'($urandom_range(0, 63));
            ba = 16'($urandom_range(0, 127));
            be = 2'($urandom_range(1, 3));
            wd = 16'($urandom);
            case (k)
                0: begin
                    cpu_op(1'b1, a, be, 16'h0, rd, lat);
                    chk("rnd_cpu_rd_lat", lat, 3);
                    chk("rnd_cpu_rd", rd, shadow[a[7:0]]);
                end
                1: begin
                    cpu_op(1'b0, a, be, wd, rd, lat);
                    sh_cpu_wr(a, be, wd);
                    chk("rnd_cpu_wr_lat", lat, 2);
                end
                2: begin
                    spi_op(1'b0, ba, 8'h00, sd, lat);
                    chk("rnd_spi_rd_lat", lat, 4);
                    chk("rnd_spi_rd", sd, sh_byte(ba));
                end
                default: begin
                    spi_op(1'b1, ba, wd[7:0], sd, lat);
                    sh_spi_wr(ba, wd[7:0]);
                    chk("rnd_spi_wr_lat", lat, 4);
                end
            endcase
        end

        // Simultaneous requests after reset: CPU first, SPI right after release;
        // a pulse while busy is dropped and flagged.
        do_reset();
        @(negedge clk);
        bus.cpu_as_n = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_addr = 15'h0010;
        bus.cpu_uds_n = 1'b0; bus.cpu_lds_n = 1'b0;
        bus.spi_wr = 1'b1; bus.spi_addr = 16'h0080; bus.spi_di = 8'h77;
        t_dt = -1; t_ack = -1; rdv = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) bus.spi_wr = 1'b0;
            if (c == 2) begin bus.spi_wr = 1'b1; bus.spi_addr = 16'h0082; bus.spi_di = 8'hEE; end
            if (c == 3) bus.spi_wr = 1'b0;
            if (t_dt < 0 && !bus.cpu_dtack_n) begin
                t_dt = c; rdv = bus.cpu_din;
                bus.cpu_as_n = 1'b1; bus.cpu_uds_n = 1'b1; bus.cpu_lds_n = 1'b1;
            end
            if (t_ack < 0 && bus.spi_ack) t_ack = c;
        end
        sh_spi_wr(16'h0080, 8'h77);
        chk("tie_cpu_lat", t_dt, 3);
        chk("tie_cpu_data", rdv, shadow[16]);
        chk("tie_spi_ack", t_ack, 7);
        chk("tie_ovr", bus.spi_ovr, 1);
        spi_op(1'b0, 16'h0080, 8'h00, sd, lat);
        chk("tie_spi_data", sd, sh_byte(16'h0080));
        spi_op(1'b0, 16'h0082, 8'h00, sd, lat);
        chk("ovr_dropped", sd, sh_byte(16'h0082));

        // CPU abort during the wait cycle.
        @(negedge clk);
        bus.cpu_as_n = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_addr = 15'h0010;
        bus.cpu_uds_n = 1'b0; bus.cpu_lds_n = 1'b0;
        seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 2) begin bus.cpu_as_n = 1'b1; bus.cpu_uds_n = 1'b1; bus.cpu_lds_n = 1'b1; end
            if (!bus.cpu_dtack_n) seen = 1;
        end
        chk("abort_no_dtack", seen, 0);
        cpu_op(1'b1, 15'h0010, 2'b11, 16'h0, rd, lat);
        chk("abort_then_lat", lat, 3);
        chk("abort_then_data", rd, shadow[16]);

        // Reset during an SPI write access.
        @(negedge clk);
        bus.spi_wr = 1'b1; bus.spi_addr = 16'h0100; bus.spi_di = 8'h33;
        seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.spi_wr = 1'b0;
            if (c == 2) begin
                reset_n = 1'b0;
                #1;
                chk("rst_acc_busy", bus.spi_busy, 0);
                chk("rst_acc_ovr", bus.spi_ovr, 0);
                chk("rst_acc_we", bus.mem_we, 0);
            end
            if (c == 3) reset_n = 1'b1;
            if (bus.spi_ack) seen = 1;
        end
        chk("rst_acc_no_ack", seen, 0);
        chk("rst_acc_idle_busy", bus.spi_busy, 0);
        spi_op(1'b0, 16'h0100, 8'h00, sd, lat);
        chk("rst_acc_rd_lat", lat, 4);
        chk("rst_acc_ram", sd, sh_byte(16'h0100));

        chk("we_single_cycle", we_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
